clk_div_n: RTL and testbench

Programmable integer clock divider, the parametrised successor to the fixed divide-by-three block. Divides `clk` by any runtime-loaded integer N from 2 to 2^WIDTH−1 and produces a 50 % duty-cycle output for both even and odd N. Divisor changes are queued and applied only at a period boundary, so `clk_out` never has a runt pulse. Sits in the clock-generation section and feeds downstream sequential logic and test clocks.

---
 rtl/clk_div_n.sv | 96 +++++++++
 tb/tb_clk_div_n.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_n.sv
// rtl/clk_div_n.sv - programmable integer clock divider with queued divisor changes
// Define CLK_DIV_ODD_DUTY_EN for exact 50% duty on odd divisors (adds a negedge phase flop).
module clk_div_n #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             div_ack,
  output logic             div_err,
  output logic             tick,
  output logic             clk_out
);

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);

  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] pend_q;
  logic             pend_v;
  logic [WIDTH-1:0] cnt;
  logic             ph_p;
  logic             run;

  logic [WIDTH-1:0] div_nx;
  logic [WIDTH-1:0] cnt_nx;
  logic             boundary;
  logic             load_ok;
  logic             apply;

  assign load_ok  = div_load && (div_in >= MIN_DIV);
  assign boundary = enable && (!run || (cnt == div_q - 1'b1));
  // While idle there is no period to protect, so a pending divisor goes in immediately.
  assign apply    = pend_v && (boundary || !enable);

  always_comb begin
    div_nx = div_q;
    cnt_nx = '0;
    if (apply) begin
      div_nx = pend_q;
    end
    if (enable && !boundary) begin
      cnt_nx = cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_q   <= DEF_DIV;
      pend_q  <= '0;
      pend_v  <= 1'b0;
      cnt     <= '0;
      ph_p    <= 1'b0;
      run     <= 1'b0;
      tick    <= 1'b0;
      div_ack <= 1'b0;
      div_err <= 1'b0;
    end else begin
      div_q   <= div_nx;
      cnt     <= cnt_nx;
      run     <= enable;
      tick    <= boundary;
      div_ack <= apply;
      div_err <= div_load && !load_ok;
      ph_p    <= enable && (cnt_nx < (div_nx >> 1));
      // A same-edge load lands after the apply, so the older value is used and the new one waits.
      if (load_ok) begin
        pend_q <= div_in;
        pend_v <= 1'b1;
      end else if (apply) begin
        pend_v <= 1'b0;
      end
    end
  end

`ifdef CLK_DIV_ODD_DUTY_EN
  logic ph_n;

  always_ff @(negedge clk) begin
    if (!reset || !enable) begin
      ph_n <= 1'b0;
    end else begin
      ph_n <= ph_p;
    end
  end

  // Gating with run drops the output on the posedge that goes idle rather than half a cycle later.
  assign clk_out = div_q[0] ? (ph_p | (ph_n & run)) : ph_p;
`else
  assign clk_out = ph_p;
`endif

endmodule

// File: tb/tb_clk_div_n.sv
// tb/tb_clk_div_n.sv - self-checking bench for clk_div_n
// Honours CLK_DIV_ODD_DUTY_EN when choosing the expected odd-divisor duty cycle.
module tb_clk_div_n;

`ifdef CLK_DIV_ODD_DUTY_EN
  localparam bit ODD_EN = 1'b1;
`else
  localparam bit ODD_EN = 1'b0;
`endif
  localparam int WIDTH = 8;
  localparam int DEF   = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic [WIDTH-1:0] div_in = '0;
  logic             div_load = 1'b0;
  logic             div_ack;
  logic             div_err;
  logic             tick;
  logic             clk_out;

  clk_div_n #(.WIDTH(WIDTH), .DEFAULT_DIV(DEF)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .div_in   (div_in),
    .div_load (div_load),
    .div_ack  (div_ack),
    .div_err  (div_err),
    .tick     (tick),
    .clk_out  (clk_out)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference: period length, position inside it, pending divisor (0 = none).
  int m_n = DEF;
  int m_pend = 0;
  int m_pos = 0;
  bit m_run = 1'b0;
  bit m_tick, m_ack, m_err, m_hi1, m_hi2;

  bit last_tick, last_ack, last_err, last_out1, last_out2;

  function automatic int high_halves(input int n);
    return (ODD_EN && (n % 2 == 1)) ? n : 2 * (n / 2);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit e, input bit l, input int d);
    bit starts;
    if (!r) begin
      m_n = DEF; m_pend = 0; m_pos = 0; m_run = 1'b0;
      m_tick = 0; m_ack = 0; m_err = 0; m_hi1 = 0; m_hi2 = 0;
      return;
    end
    m_err  = l && (d < 2);
    starts = e && (!m_run || m_pos == m_n - 1);
    m_ack  = (m_pend != 0) && (starts || !e);
    if (m_ack) begin
      m_n = m_pend;
      m_pend = 0;
    end
    if (l && d >= 2) m_pend = d;
    m_tick = starts;
    if (!e) begin
      m_pos = 0; m_run = 1'b0; m_hi1 = 0; m_hi2 = 0;
    end else begin
      m_pos = starts ? 0 : m_pos + 1;
      m_run = 1'b1;
      m_hi1 = (2 * m_pos) < high_halves(m_n);
      m_hi2 = (2 * m_pos + 1) < high_halves(m_n);
    end
  endtask

  task automatic step(input bit r, input bit e, input bit l, input int d);
    reset = r; enable = e; div_load = l; div_in = WIDTH'(d);
    model_edge(r, e, l, d);
    @(posedge clk); #1;
    last_tick = tick; last_ack = div_ack; last_err = div_err; last_out1 = clk_out;
    chk("tick", tick, m_tick);
    chk("div_ack", div_ack, m_ack);
    chk("div_err", div_err, m_err);
    chk("clk_out_first_half", clk_out, m_hi1);
    @(negedge clk); #1;
    last_out2 = clk_out;
    chk("clk_out_second_half", clk_out, m_hi2);
  endtask

  // Call right after a step that showed tick; runs to the next tick.
  task automatic measure_period(output int len, output int hi, output int acks);
    bit found = 1'b0;
    len = 1; hi = int'(last_out1) + int'(last_out2); acks = 0;
    for (int k = 0; k < 300; k++) begin
      step(1, 1, 0, 0);
      if (last_tick) begin
        found = 1'b1;
        break;
      end
      len++;
      hi += int'(last_out1) + int'(last_out2);
      acks += int'(last_ack);
    end
    chk("period_end_seen", found, 1);
  endtask

  typedef struct {
    bit r, e, l;
    int d;
    bit tk, ak, er;
    bit [1:0] out_p, out_o;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int len, hi, acks;
    bit found;
    bit [1:0] exp_out;

    tbl[0]  = '{0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00};
    tbl[1]  = '{0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00};
    tbl[2]  = '{1, 1, 0, 0, 1, 0, 0, 2'b11, 2'b11};
    tbl[3]  = '{1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b10};
    tbl[4]  = '{1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00};
    tbl[5]  = '{1, 1, 1, 4, 1, 0, 0, 2'b11, 2'b11};
    tbl[6]  = '{1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b10};
    tbl[7]  = '{1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00};
    tbl[8]  = '{1, 1, 0, 0, 1, 1, 0, 2'b11, 2'b11};
    tbl[9]  = '{1, 1, 0, 0, 0, 0, 0, 2'b11, 2'b11};
    tbl[10] = '{1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00};
    tbl[11] = '{1, 1, 1, 1, 0, 0, 1, 2'b00, 2'b00};
    tbl[12] = '{1, 1, 1, 0, 1, 0, 1, 2'b11, 2'b11};
    tbl[13] = '{1, 1, 0, 0, 0, 0, 0, 2'b11, 2'b11};
    tbl[14] = '{0, 1, 1, 9, 0, 0, 0, 2'b00, 2'b00};

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].r, tbl[i].e, tbl[i].l, tbl[i].d);
      exp_out = ODD_EN ? tbl[i].out_o : tbl[i].out_p;
      chk("tbl_tick", last_tick, tbl[i].tk);
      chk("tbl_ack", last_ack, tbl[i].ak);
      chk("tbl_err", last_err, tbl[i].er);
      chk("tbl_clk_out", {last_out1, last_out2}, exp_out);
    end

    // Two loads before a boundary: only the latest is applied, once.
    step(1, 1, 0, 0);
    step(1, 1, 1, 5);
    step(1, 1, 1, 7);
    step(1, 1, 0, 0);
    chk("latest_wins_ack_with_tick", {last_tick, last_ack}, 2'b11);
    measure_period(len, hi, acks);
    chk("div7_len", len, 7);
    chk("div7_high_halves", hi, ODD_EN ? 7 : 6);
    chk("div7_single_ack", acks, 0);

    // N=6, drop enable mid-period, then re-enable.
    step(1, 1, 1, 6);
    found = 1'b0;
    for (int k = 0; k < 50; k++) begin
      step(1, 1, 0, 0);
      if (last_ack) begin
        found = 1'b1;
        break;
      end
    end
    chk("div6_ack_seen", found, 1);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    chk("idle_low", {last_out1, last_out2}, 2'b00);
    chk("idle_no_tick", last_tick, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    chk("reenable_tick", {last_tick, last_out1}, 2'b11);
    measure_period(len, hi, acks);
    chk("div6_len", len, 6);
    chk("div6_high_halves", hi, 6);

    // Reset at cnt=2 with 9 pending.
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 1, 9);
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("reset_outputs", {last_tick, last_ack, last_err, last_out1, last_out2}, 5'b0);
    step(1, 1, 0, 0);
    chk("post_reset_tick_no_ack", {last_tick, last_ack}, 2'b10);
    measure_period(len, hi, acks);
    chk("post_reset_len", len, 3);
    chk("post_reset_high_halves", hi, ODD_EN ? 3 : 2);
    chk("pending_lost", acks, 0);

    for (int k = 0; k < 600; k++) begin
      bit r, e, l;
      int d;
      r = ($urandom_range(0, 63) != 0);
      e = ($urandom_range(0, 15) != 0);
      l = ($urandom_range(0, 5) == 0);
      d = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 9));
      step(r, e, l, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
